harq_rdm_combiner: RTL and testbench
====================================

# harq_rdm_combiner

Receiving end of the RDM stream produced by the HARQ send FSM. Once a combine is started, it requests RDM data, accepts 96-bit words of 16 six-bit LLRs, and combines each word with the soft bits already held in the HARQ buffer RAM using a saturating add. It then writes the result back. It sits between the HARQ send FSM and the HARQ buffer RAM, and reports completion to the combine controller.

## Interface
- No parameters. Widths are fixed: 96-bit word = 16 LLRs × 6 bits, two's complement, LLR j in bits [6j+5:6j].
- i_core_clk  in  1  sole clock, all logic on rising edge.
- i_rx_rst  in  1  asynchronous, active-high reset.
- i_Combine_process_request  in  1  start; sampled only in IDLE.
- i_Current_Combine_Ncb_Size  in  16  Ncb−1 (index of last LLR); sampled at start.
- i_First_Transmission  in  1  1 = no combining, new LLRs stored as-is; sampled at start.
- i_HARQ_Base_Address  in  12  RAM word address of LLR 0; sampled at start.
- o_RDM_Data_Request  out  1  request to sender.
- i_RDM_Data_Valid  in  1  content word valid.
- i_RDM_Data_Content  in  96  16 LLRs.
- i_RDM_Data_Comp  in  1  sender finished.
- o_HARQ_Rd_Enable  out  1  RAM read strobe; RAM returns data in the next cycle.
- o_HARQ_Rd_Address  out  12  read word address.
- i_HARQ_Rd_Data  in  96  stored LLRs; 1-cycle read latency.
- o_HARQ_Wr_Enable  out  1  RAM write strobe.
- o_HARQ_Wr_Address  out  12  write word address.
- o_HARQ_Wr_Data  out  96  combined LLRs.
- o_Combine_Done  out  1  one-cycle completion pulse.
- o_Short_Error  out  1  comp arrived before all words were received. Held until the next start.

## Operation
- Word count: N = Ncb[15:4] + 1, 12-bit. The last word carries L = Ncb[3:0] + 1 valid LLRs. All other words carry 16.
- FSM states: IDLE, REQUEST, RECEIVE, FLUSH, DONE.
- IDLE → REQUEST on i_Combine_process_request=1. The start action latches Ncb, first-transmission flag and base, clears the word counter k, and clears o_Short_Error.
- REQUEST:
  - o_RDM_Data_Request=1 while in REQUEST.
  - The first i_RDM_Data_Valid is accepted as word 0.
  - The FSM moves to RECEIVE in the same cycle.
- RECEIVE:
  - Each cycle with i_RDM_Data_Valid=1 accepts word k and increments k.
  - Acceptance of word N−1 → FLUSH.
  - i_RDM_Data_Comp=1 with k<N and no valid in the same cycle → set o_Short_Error, go to FLUSH.
- FLUSH: wait until the pipeline is empty (2 cycles after the last accepted word), then go to DONE.
- DONE: o_Combine_Done=1 for one cycle, then IDLE.
- Valid or comp in IDLE, FLUSH or DONE is ignored. Words beyond N are ignored.
- Acceptance of word k, cycle t:
  - o_HARQ_Rd_Enable=1 and o_HARQ_Rd_Address=(base+k) mod 4096, combinationally from valid and k.
  - The content and a per-LLR mask are registered.
- Cycle t+1:
  - Per LLR j: if mask[j]=0, out=old (keeps the stored value).
  - Else if first transmission, out=new.
  - Else out=sat(old+new). The sum is formed at 7 bits and clamped to [−32,+31].
  - The result is registered into the write port.
- Cycle t+2: o_HARQ_Wr_Enable=1 with the address of word k.
- Mask: all ones except for the last word (k=N−1), where mask[j]=1 for j<L only.
- Addresses strictly increase (mod 4096) within a combine, so there is no read-after-write hazard.

## Timing
- Reset values: every output = 0, FSM=IDLE, counters = 0.
- Reset asserted mid-operation: immediate return to IDLE. In-flight writes are dropped and no done pulse is produced.
- o_RDM_Data_Request rises the cycle after start is sampled. It stays high until the first valid is accepted, and falls in the following cycle.
- Valid to RAM write: 2 cycles. Fully pipelined: one word per cycle, any gaps in valid allowed.
- Valid and comp in the same cycle: the word is accepted first. The error is set only if k+1<N.
- Last write occurs at t_last+2. The FSM enters DONE so that o_Combine_Done is high at t_last+3.
- A start during a non-IDLE state is ignored.

## Test plan
- First transmission, Ncb−1=47, base=0x010, three back-to-back words:
  - Three writes to 0x010, 0x011 and 0x012, data equal to the input.
  - Done pulse 3 cycles after the third valid; o_Short_Error=0.
- Combine, Ncb−1=15, stored LLRs {+20,−20,+5,−32}, new {+20,−20,−7,−1} → written {+31,−32,−2,−32}.
- Partial last word, Ncb−1=36, combine on:
  - Word 2 writes LLRs 0..4 as sums.
  - LLRs 5..15 equal the stored values.
- Gapped valid (one valid every 3 cycles), base=4095, Ncb−1=31:
  - Writes to addresses 4095 then 0.
  - Request is high only until the first valid.
- Early comp after 1 of 3 words, Ncb−1=47:
  - One write.
  - o_Short_Error=1 and a done pulse, then IDLE.
  - A later valid causes no write.
- Reset pulsed while in RECEIVE after 1 word:
  - All outputs 0 within the reset cycle, no further writes, no done pulse.
  - A new start afterwards completes normally.

Source files
------------

// File: rtl/harq_rdm_combiner.sv
//------------------------------------------------------------------------------
// harq_rdm_combiner
//
// Receives the rate-dematched (RDM) LLR stream for one code block and merges it
// into the HARQ soft buffer. Each accepted 96-bit word (16 x 6-bit LLRs) is
// combined with the soft bits already stored at the same buffer address:
//   - first transmission : the new LLRs overwrite the stored ones
//   - retransmission     : stored + new, saturated to [-32, +31]
// LLRs past the end of the code block (the tail of the last word) keep their
// stored value, so neighbouring data in that RAM word is never disturbed.
//
// Pipeline, for a word accepted in cycle t:
//   t   : RAM read issued, new LLRs and the valid-LLR mask registered
//   t+1 : RAM data returns, merge computed and registered
//   t+2 : RAM write of the merged word
// One word per cycle; gaps in the valid stream are allowed.
//
// Ports
//   i_core_clk                  clock, all logic on the rising edge
//   i_rx_rst                    asynchronous active-high reset
//   i_Combine_process_request   start request (only honoured in IDLE)
//   i_Current_Combine_Ncb_Size  Ncb-1, index of the last LLR (latched at start)
//   i_First_Transmission        1 = store new LLRs unmodified (latched at start)
//   i_HARQ_Base_Address         buffer word address of LLR 0 (latched at start)
//   o_RDM_Data_Request          asks the sender for data until the first word
//   i_RDM_Data_Valid            content word valid
//   i_RDM_Data_Content          16 LLRs, LLR j in bits [6j+5:6j]
//   i_RDM_Data_Comp             sender has finished
//   o_HARQ_Rd_Enable/_Address   buffer read port (data returns next cycle)
//   i_HARQ_Rd_Data              buffer read data
//   o_HARQ_Wr_Enable/_Address/_Data  buffer write port
//   o_Combine_Done              one-cycle completion pulse
//   o_Short_Error               sender finished before all words arrived;
//                               held until the next start
//------------------------------------------------------------------------------
module harq_rdm_combiner (
  input  logic        i_core_clk,
  input  logic        i_rx_rst,
  input  logic        i_Combine_process_request,
  input  logic [15:0] i_Current_Combine_Ncb_Size,
  input  logic        i_First_Transmission,
  input  logic [11:0] i_HARQ_Base_Address,
  output logic        o_RDM_Data_Request,
  input  logic        i_RDM_Data_Valid,
  input  logic [95:0] i_RDM_Data_Content,
  input  logic        i_RDM_Data_Comp,
  output logic        o_HARQ_Rd_Enable,
  output logic [11:0] o_HARQ_Rd_Address,
  input  logic [95:0] i_HARQ_Rd_Data,
  output logic        o_HARQ_Wr_Enable,
  output logic [11:0] o_HARQ_Wr_Address,
  output logic [95:0] o_HARQ_Wr_Data,
  output logic        o_Combine_Done,
  output logic        o_Short_Error
);

  localparam int NUM_LLR = 16;
  localparam int LLR_W   = 6;
  localparam int WORD_W  = NUM_LLR * LLR_W;
  localparam int ADDR_W  = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_RECEIVE,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t state_reg, state_next;

  // Parameters of the combine in progress, captured at start.
  logic [15:0]        ncb_reg;
  logic               first_reg;
  logic [ADDR_W-1:0]  base_reg;

  // Number of words accepted so far (index of the next word).
  logic [ADDR_W-1:0]  k_reg, k_next;
  logic               short_err_reg, short_err_next;

  logic               start;
  logic               accept;
  logic               last_word;
  logic [ADDR_W-1:0]  word_addr;
  logic [NUM_LLR-1:0] mask;

  // Stage 1: word waiting for its RAM read data.
  logic               s1_valid_reg;
  logic [ADDR_W-1:0]  s1_addr_reg;
  logic [WORD_W-1:0]  s1_new_reg;
  logic [NUM_LLR-1:0] s1_mask_reg;

  // Stage 2: merged word being written back.
  logic               wr_en_reg;
  logic [ADDR_W-1:0]  wr_addr_reg;
  logic [WORD_W-1:0]  wr_data_reg;

  logic [WORD_W-1:0]  merged;

  //----------------------------------------------------------------------------
  // Word acceptance and addressing
  //----------------------------------------------------------------------------
  assign accept = i_RDM_Data_Valid &&
                  ((state_reg == ST_REQUEST) || (state_reg == ST_RECEIVE));

  // Word N-1 is the last one; N-1 is simply Ncb[15:4], which avoids the
  // 12-bit wrap of N itself when Ncb[15:4] is all ones.
  assign last_word = (k_reg == ncb_reg[15:4]);

  // Buffer addresses wrap modulo 4096 through the natural 12-bit overflow.
  assign word_addr = base_reg + k_reg;

  // On the last word only LLRs 0..Ncb[3:0] belong to the code block.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LLR; gi++) begin : g_mask
      assign mask[gi] = !last_word || (4'(gi) <= ncb_reg[3:0]);
    end
  endgenerate

  //----------------------------------------------------------------------------
  // Control FSM
  //----------------------------------------------------------------------------
  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      state_reg     <= ST_IDLE;
      k_reg         <= '0;
      short_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      k_reg         <= k_next;
      short_err_reg <= short_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    k_next         = k_reg;
    short_err_next = short_err_reg;
    start          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (i_Combine_process_request) begin
          start          = 1'b1;
          state_next     = ST_REQUEST;
          k_next         = '0;
          short_err_next = 1'b0;
        end
      end

      ST_REQUEST: begin
        // A single-word block is complete with its first word, so it goes
        // straight to FLUSH rather than waiting in RECEIVE.
        if (accept) begin
          k_next     = k_reg + 12'd1;
          state_next = last_word ? ST_FLUSH : ST_RECEIVE;
        end
      end

      ST_RECEIVE: begin
        if (accept) begin
          k_next = k_reg + 12'd1;
          if (last_word) begin
            state_next = ST_FLUSH;
          end else if (i_RDM_Data_Comp) begin
            // The word arriving with comp is kept, but more were owed.
            short_err_next = 1'b1;
            state_next     = ST_FLUSH;
          end
        end else if (i_RDM_Data_Comp) begin
          // In RECEIVE k is always below N, so comp here is always early.
          short_err_next = 1'b1;
          state_next     = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        // Once stage 1 is empty the final write is being issued this cycle,
        // so DONE lands one cycle after the last write.
        if (!s1_valid_reg) begin
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Combine parameters only change on start, so they stay stable while the
  // pipeline drains.
  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      ncb_reg   <= '0;
      first_reg <= 1'b0;
      base_reg  <= '0;
    end else if (start) begin
      ncb_reg   <= i_Current_Combine_Ncb_Size;
      first_reg <= i_First_Transmission;
      base_reg  <= i_HARQ_Base_Address;
    end
  end

  //----------------------------------------------------------------------------
  // Stage 1: hold the new word while the RAM read is in flight
  //----------------------------------------------------------------------------
  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      s1_valid_reg <= 1'b0;
      s1_addr_reg  <= '0;
      s1_new_reg   <= '0;
      s1_mask_reg  <= '0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_addr_reg <= word_addr;
        s1_new_reg  <= i_RDM_Data_Content;
        s1_mask_reg <= mask;
      end
    end
  end

  //----------------------------------------------------------------------------
  // Per-LLR merge of stored and new soft bits
  //----------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NUM_LLR; gi++) begin : g_llr
      logic [LLR_W-1:0] old_llr;
      logic [LLR_W-1:0] new_llr;
      logic [LLR_W:0]   sum;
      logic [LLR_W-1:0] sat;

      assign old_llr = i_HARQ_Rd_Data[gi*LLR_W +: LLR_W];
      assign new_llr = s1_new_reg[gi*LLR_W +: LLR_W];

      // Sign-extend both operands to 7 bits; the sum cannot overflow there.
      assign sum = {old_llr[LLR_W-1], old_llr} + {new_llr[LLR_W-1], new_llr};

      // The result fits in 6 bits when the two top bits agree; otherwise the
      // true sign (bit 6) picks the clamp value.
      assign sat = (sum[LLR_W] == sum[LLR_W-1]) ? sum[LLR_W-1:0] :
                   (sum[LLR_W] ? 6'b100000 : 6'b011111);

      assign merged[gi*LLR_W +: LLR_W] = !s1_mask_reg[gi] ? old_llr :
                                         first_reg        ? new_llr : sat;
    end
  endgenerate

  //----------------------------------------------------------------------------
  // Stage 2: registered write port
  //----------------------------------------------------------------------------
  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        wr_addr_reg <= s1_addr_reg;
        wr_data_reg <= merged;
      end
    end
  end

  //----------------------------------------------------------------------------
  // Outputs
  //----------------------------------------------------------------------------
  assign o_RDM_Data_Request = (state_reg == ST_REQUEST);
  assign o_HARQ_Rd_Enable   = accept;
  // Address is forced to zero when no read is issued to keep the bus quiet.
  assign o_HARQ_Rd_Address  = accept ? word_addr : '0;
  assign o_HARQ_Wr_Enable   = wr_en_reg;
  assign o_HARQ_Wr_Address  = wr_addr_reg;
  assign o_HARQ_Wr_Data     = wr_data_reg;
  assign o_Combine_Done     = (state_reg == ST_DONE);
  assign o_Short_Error      = short_err_reg;

endmodule

// File: tb/tb_harq_rdm_combiner.sv
//------------------------------------------------------------------------------
// Testbench for harq_rdm_combiner. A behavioural HARQ buffer RAM (1-cycle read)
// is attached to the DUT. A shadow copy of the buffer plus an LLR-level
// reference merge produce the expected writes, write cycles, done cycle and
// short-error flag for every combine.
//------------------------------------------------------------------------------
module tb_harq_rdm_combiner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_req;
  logic [15:0] ncb_in;
  logic        first_in;
  logic [11:0] base_in;
  logic        rdm_req;
  logic        rdm_valid;
  logic [95:0] rdm_data;
  logic        rdm_comp;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic [95:0] rd_data;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [95:0] wr_data;
  logic        done;
  logic        short_err;

  always #5 clk = ~clk;

  harq_rdm_combiner dut (
    .i_core_clk                 (clk),
    .i_rx_rst                   (rst),
    .i_Combine_process_request  (start_req),
    .i_Current_Combine_Ncb_Size (ncb_in),
    .i_First_Transmission       (first_in),
    .i_HARQ_Base_Address        (base_in),
    .o_RDM_Data_Request         (rdm_req),
    .i_RDM_Data_Valid           (rdm_valid),
    .i_RDM_Data_Content         (rdm_data),
    .i_RDM_Data_Comp            (rdm_comp),
    .o_HARQ_Rd_Enable           (rd_en),
    .o_HARQ_Rd_Address          (rd_addr),
    .i_HARQ_Rd_Data             (rd_data),
    .o_HARQ_Wr_Enable           (wr_en),
    .o_HARQ_Wr_Address          (wr_addr),
    .o_HARQ_Wr_Data             (wr_data),
    .o_Combine_Done             (done),
    .o_Short_Error              (short_err)
  );

  // HARQ buffer RAM with registered read.
  logic [95:0] mem [0:4095];
  logic        ram_clr;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Cycle counter and write / done monitor (sampled on the falling edge).
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          wq_addr [$];
  logic [95:0] wq_data [$];
  int          wq_cyc  [$];
  int          dq_cyc  [$];
  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(int'(wr_addr));
      wq_data.push_back(wr_data);
      wq_cyc.push_back(cyc);
    end
    if (done) dq_cyc.push_back(cyc);
  end

  // Expected buffer contents.
  logic [95:0] shadow [0:4095];
  logic [95:0] word_buf [0:15];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int llr_val(input logic [95:0] w, input int j);
    logic [5:0] b;
    b = w[j*6 +: 6];
    return b[5] ? int'(b) - 64 : int'(b);
  endfunction

  // Reference merge: LLRs at index >= nvalid keep the stored value.
  function automatic logic [95:0] ref_merge(input logic [95:0] old_w, input logic [95:0] new_w,
                                            input bit first, input int nvalid);
    logic [95:0] r;
    int o, n, s;
    r = '0;
    for (int j = 0; j < 16; j++) begin
      o = llr_val(old_w, j);
      n = llr_val(new_w, j);
      if (j >= nvalid) s = o;
      else if (first) s = n;
      else begin
        s = o + n;
        if (s > 31) s = 31;
        if (s < -32) s = -32;
      end
      r[j*6 +: 6] = 6'(s);
    end
    return r;
  endfunction

  function automatic logic [95:0] rand_word();
    return {$urandom, $urandom, $urandom};
  endfunction

  // One clock cycle of sender activity; checks the request line mid-cycle.
  task automatic step(input bit v, input logic [95:0] d, input bit c, input bit exp_req, output int t);
    rdm_valid = v;
    rdm_data  = d;
    rdm_comp  = c;
    @(negedge clk);
    t = cyc;
    chk("rdm_request", 96'(rdm_req), 96'(exp_req));
    @(posedge clk); #1;
    rdm_valid = 1'b0;
    rdm_comp  = 1'b0;
    rdm_data  = '0;
  endtask

  // Runs one combine: nsend words from word_buf with `gap` idle cycles before
  // each, comp riding on word comp_idx (-1: none), and a closing comp-only
  // cycle right after the last word.
  task automatic run_combine(input int ncb, input bit first, input int base, input int nsend,
                             input int gap, input int comp_idx, input string name);
    int nw, acc, t, t_last, exp_done, wr0, dn0, nvalid, a, waited, nexp;
    bit stopped, exp_err;
    int          exp_addr [$];
    logic [95:0] exp_data [$];
    int          exp_cyc  [$];
    logic [95:0] d;

    nw = ncb / 16 + 1;
    wr0 = wq_addr.size();
    dn0 = dq_cyc.size();
    acc = 0; stopped = 1'b0; exp_err = 1'b0; t_last = 0; exp_done = -1;

    start_req = 1'b1;
    ncb_in    = 16'(ncb);
    first_in  = first;
    base_in   = 12'(base);
    @(posedge clk); #1;
    start_req = 1'b0;
    @(negedge clk);
    chk("err_cleared_at_start", 96'(short_err), 96'(0));
    chk("request_after_start", 96'(rdm_req), 96'(1));
    @(posedge clk); #1;

    for (int i = 0; i < nsend; i++) begin
      for (int g = 0; g < gap; g++) step(1'b0, '0, 1'b0, acc == 0, t);
      step(1'b1, word_buf[i], i == comp_idx, acc == 0, t);
      if (!stopped) begin
        nvalid = (acc == nw - 1) ? (ncb % 16) + 1 : 16;
        a = (base + acc) % 4096;
        d = ref_merge(shadow[a], word_buf[i], first, nvalid);
        exp_addr.push_back(a);
        exp_data.push_back(d);
        exp_cyc.push_back(t + 2);
        shadow[a] = d;
        acc++;
        t_last = t;
        if (acc == nw) stopped = 1'b1;
        else if (i == comp_idx) begin
          stopped = 1'b1;
          exp_err = 1'b1;
        end
        if (stopped) exp_done = t + 3;
      end
    end

    step(1'b0, '0, 1'b1, acc == 0, t);
    if (!stopped) begin
      exp_err = 1'b1;
      exp_done = (t_last + 3 > t + 2) ? t_last + 3 : t + 2;
    end

    waited = 0;
    while (dq_cyc.size() == dn0 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    // A valid after completion must be ignored.
    step(1'b1, rand_word(), 1'b0, 1'b0, t);
    repeat (4) @(posedge clk);
    #1;

    chk({name, ".done_count"}, 96'(dq_cyc.size() - dn0), 96'(1));
    if (dq_cyc.size() > dn0) chk({name, ".done_cycle"}, 96'(dq_cyc[dn0]), 96'(exp_done));
    chk({name, ".short_error"}, 96'(short_err), 96'(exp_err));
    chk({name, ".write_count"}, 96'(wq_addr.size() - wr0), 96'(exp_addr.size()));
    nexp = exp_addr.size();
    for (int i = 0; i < nexp && wr0 + i < wq_addr.size(); i++) begin
      chk({name, ".wr_addr"}, 96'(wq_addr[wr0 + i]), 96'(exp_addr[i]));
      chk({name, ".wr_data"}, wq_data[wr0 + i], exp_data[i]);
      chk({name, ".wr_cycle"}, 96'(wq_cyc[wr0 + i]), 96'(exp_cyc[i]));
    end
    $display("combine %s: ncb-1=%0d first=%0d base=%03h sent=%0d accepted=%0d short_err=%0d",
             name, ncb, first, base, nsend, acc, exp_err);
  endtask

  initial begin
    int t, wr0, dn0, ncb, nw, nsend, cidx;
    logic [95:0] w;
    logic [23:0] low_exp;

    rst = 1'b1; start_req = 1'b0; ncb_in = '0; first_in = 1'b0; base_in = '0;
    rdm_valid = 1'b0; rdm_data = '0; rdm_comp = 1'b0; ram_clr = 1'b1;
    for (int a = 0; a < 4096; a++) shadow[a] = '0;
    repeat (3) @(posedge clk);
    #1;

    chk("reset.request",   96'(rdm_req),   96'(0));
    chk("reset.rd_en",     96'(rd_en),     96'(0));
    chk("reset.rd_addr",   96'(rd_addr),   96'(0));
    chk("reset.wr_en",     96'(wr_en),     96'(0));
    chk("reset.wr_addr",   96'(wr_addr),   96'(0));
    chk("reset.wr_data",   wr_data,        96'(0));
    chk("reset.done",      96'(done),      96'(0));
    chk("reset.short_err", 96'(short_err), 96'(0));
    rst = 1'b0;
    ram_clr = 1'b0;
    @(posedge clk); #1;

    // First transmission, three back-to-back words, comp with the last one.
    for (int i = 0; i < 3; i++) word_buf[i] = rand_word();
    run_combine(47, 1'b1, 'h010, 3, 0, 2, "first_tx");

    // Saturating combine on a single-word block.
    w = rand_word();
    w[5:0] = 6'(20); w[11:6] = 6'(-20); w[17:12] = 6'(5); w[23:18] = 6'(-32);
    word_buf[0] = w;
    run_combine(15, 1'b1, 'h100, 1, 0, -1, "store_directed");
    w = rand_word();
    w[5:0] = 6'(20); w[11:6] = 6'(-20); w[17:12] = 6'(-7); w[23:18] = 6'(-1);
    word_buf[0] = w;
    run_combine(15, 1'b0, 'h100, 1, 0, -1, "combine_sat");
    low_exp = {6'h20, 6'h3E, 6'h20, 6'h1F};
    chk("combine_sat.llr0_3", 96'(wq_data[wq_data.size() - 1][23:0]), 96'(low_exp));

    // Partial last word (5 valid LLRs in word 2).
    for (int i = 0; i < 3; i++) word_buf[i] = rand_word();
    run_combine(36, 1'b1, 'h200, 3, 0, -1, "partial_store");
    for (int i = 0; i < 3; i++) word_buf[i] = rand_word();
    run_combine(36, 1'b0, 'h200, 3, 0, -1, "partial_combine");

    // One valid every third cycle, wrapping from 4095 to 0.
    for (int i = 0; i < 2; i++) word_buf[i] = rand_word();
    run_combine(31, 1'b1, 4095, 2, 2, -1, "gapped_wrap_store");
    chk("gapped.addr0", 96'(wq_addr[wq_addr.size() - 2]), 96'(4095));
    chk("gapped.addr1", 96'(wq_addr[wq_addr.size() - 1]), 96'(0));
    for (int i = 0; i < 2; i++) word_buf[i] = rand_word();
    run_combine(31, 1'b0, 4095, 2, 2, -1, "gapped_wrap_combine");

    // Sender finishes after 1 of 3 words.
    word_buf[0] = rand_word();
    run_combine(47, 1'b1, 'h300, 1, 0, -1, "early_comp");

    // Comp together with word 1 of 3; word 2 arrives too late.
    for (int i = 0; i < 3; i++) word_buf[i] = rand_word();
    run_combine(47, 1'b0, 'h300, 3, 0, 1, "comp_with_word");

    // Reset while receiving, with one word still in the pipeline.
    wr0 = wq_addr.size();
    dn0 = dq_cyc.size();
    start_req = 1'b1; ncb_in = 16'(47); first_in = 1'b1; base_in = 12'h500;
    @(posedge clk); #1;
    start_req = 1'b0;
    step(1'b1, rand_word(), 1'b0, 1'b1, t);
    rst = 1'b1;
    #1;
    chk("midrst.request",   96'(rdm_req),   96'(0));
    chk("midrst.rd_en",     96'(rd_en),     96'(0));
    chk("midrst.rd_addr",   96'(rd_addr),   96'(0));
    chk("midrst.wr_en",     96'(wr_en),     96'(0));
    chk("midrst.wr_addr",   96'(wr_addr),   96'(0));
    chk("midrst.wr_data",   wr_data,        96'(0));
    chk("midrst.done",      96'(done),      96'(0));
    chk("midrst.short_err", 96'(short_err), 96'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst.no_write", 96'(wq_addr.size() - wr0), 96'(0));
    chk("midrst.no_done",  96'(dq_cyc.size() - dn0),  96'(0));
    $display("reset mid-receive: pipeline word dropped");
    for (int i = 0; i < 3; i++) word_buf[i] = rand_word();
    run_combine(47, 1'b0, 'h500, 3, 0, -1, "after_reset");

    // Randomised combines.
    for (int r = 0; r < 8; r++) begin
      ncb = int'($urandom_range(0, 16 * 5 - 1));
      nw = ncb / 16 + 1;
      nsend = nw + int'($urandom_range(0, 1));
      if (nw > 1 && $urandom_range(0, 3) == 0) nsend = int'($urandom_range(1, nw - 1));
      cidx = -1;
      if (nsend >= 2 && $urandom_range(0, 2) == 0) cidx = int'($urandom_range(1, nsend - 1));
      for (int i = 0; i < nsend; i++) word_buf[i] = rand_word();
      run_combine(ncb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)), nsend,
                  int'($urandom_range(0, 2)), cidx, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
